// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a frame-synchronous shadow register.
// Latency: seg_out/dig_sel are registered one cycle after idx/disp; a write is visible within DIGITS*SCAN_DIV cycles.
// Backpressure: wr_ready drops while a posted value waits for frame end; wr_valid is ignored meanwhile.
module seg7_scan_ctrl #(
   parameter int DIGITS         = 4,
   parameter int SCAN_DIV       = 1000,
   parameter bit LZ_SUPPRESS    = 1'b0,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DIG_ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [4*DIGITS-1:0]   wr_data,
   input  logic [DIGITS-1:0]     wr_dp,
   input  logic                  disp_en,
   output logic [7:0]            seg_out,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  frame_end
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic                term;
   logic                pending;
   logic [4*DIGITS-1:0] shadow;
   logic [4*DIGITS-1:0] disp;
   logic [DIGITS-1:0]   shadow_dp;
   logic [DIGITS-1:0]   disp_dp;
   logic [DIGITS-1:0]   blank;
   logic                zero_run;
   logic [3:0]          nibble;
   logic [7:0]          seg_nx;
   logic [DIGITS-1:0]   dig_nx;
   logic [7:0]          seg_q;
   logic [DIGITS-1:0]   dig_q;

   function automatic logic [7:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 8'hFC;
         4'h1: hex_seg = 8'h60;
         4'h2: hex_seg = 8'hDA;
         4'h3: hex_seg = 8'hF2;
         4'h4: hex_seg = 8'h66;
         4'h5: hex_seg = 8'hB6;
         4'h6: hex_seg = 8'hBE;
         4'h7: hex_seg = 8'hE0;
         4'h8: hex_seg = 8'hFE;
         4'h9: hex_seg = 8'hF6;
         4'hA: hex_seg = 8'hEE;
         4'hB: hex_seg = 8'h3E;
         4'hC: hex_seg = 8'h1A;
         4'hD: hex_seg = 8'h7A;
         4'hE: hex_seg = 8'h9E;
         default: hex_seg = 8'h8E;
      endcase
   endfunction

   assign term      = (cnt == CNT_LAST);
   assign frame_end = term && (idx == IDX_LAST);
   assign wr_ready  = !pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= term ? '0 : cnt + 1'b1;
         if (term)
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
   end

   // Commit and accept are mutually exclusive: one needs pending set, the other clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= 1'b0;
         shadow    <= '0;
         shadow_dp <= '0;
         disp      <= '0;
         disp_dp   <= '0;
      end else if (frame_end && pending) begin
         disp      <= shadow;
         disp_dp   <= shadow_dp;
         pending   <= 1'b0;
      end else if (wr_valid && !pending) begin
         shadow    <= wr_data;
         shadow_dp <= wr_dp;
         pending   <= 1'b1;
      end
   end

   // Walk from the top digit down; a digit is blank while everything at or above it is zero with no dp.
   always_comb begin
      zero_run = 1'b1;
      blank    = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (disp[4*i +: 4] == 4'h0) && !disp_dp[i];
         blank[i] = LZ_SUPPRESS && (i != 0) && zero_run;
      end
   end

   always_comb begin
      nibble    = disp[4*idx +: 4];
      seg_nx    = hex_seg(nibble);
      seg_nx[0] = disp_dp[idx];
      if (blank[idx])
         seg_nx = 8'h00;
      dig_nx      = '0;
      dig_nx[idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= '0;
         dig_q <= '0;
      end else begin
         seg_q <= disp_en ? seg_nx : 8'h00;
         dig_q <= disp_en ? dig_nx : '0;
      end
   end

   assign seg_out = seg_q ^ {8{SEG_ACTIVE_LOW}};
   assign dig_sel = dig_q ^ {DIGITS{DIG_ACTIVE_LOW}};

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (plain, and LZ-suppress with inverted polarity) share stimulus.
// Latency: expectations come from a cycle-count reference model of scan position, frame timing and commit.
// Backpressure: writes during pending are driven deliberately and must be dropped.
module tb_seg7_scan_ctrl;

   localparam int D  = 4;
   localparam int S  = 4;
   localparam int FR = D * S;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic [15:0] wr_data;
   logic [3:0]  wr_dp;
   logic        disp_en;
   logic        rdy_a, rdy_b, fe_a, fe_b;
   logic [7:0]  seg_a, seg_b;
   logic [3:0]  dig_a, dig_b;

   int tests = 0;
   int fails = 0;

   // Reference model state: t counts rising edges since reset release.
   int          t;
   bit          m_pend;
   logic [15:0] m_sh, m_disp;
   logic [3:0]  m_shdp, m_dp;
   logic [7:0]  m_seg_a, m_seg_b;
   logic [3:0]  m_dig;

   logic [7:0] tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                            8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S)) dut_a (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_a),
      .wr_data(wr_data), .wr_dp(wr_dp), .disp_en(disp_en),
      .seg_out(seg_a), .dig_sel(dig_a), .frame_end(fe_a));

   seg7_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .LZ_SUPPRESS(1'b1),
                    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy_b),
      .wr_data(wr_data), .wr_dp(wr_dp), .disp_en(disp_en),
      .seg_out(seg_b), .dig_sel(dig_b), .frame_end(fe_b));

   function automatic logic [7:0] seg_of(input logic [15:0] v, input logic [3:0] dp,
                                         input int d, input bit lz);
      logic [3:0] nib;
      nib = 4'((v >> (4 * d)) & 16'h000F);
      if (lz && d > 0 && (v >> (4 * d)) == 16'h0 && (dp >> d) == 4'h0)
         return 8'h00;
      return tbl[nib] | {7'b0, dp[d]};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic model_reset();
      t = 0; m_pend = 0; m_sh = '0; m_disp = '0; m_shdp = '0; m_dp = '0;
      m_seg_a = '0; m_seg_b = '0; m_dig = '0;
   endtask

   task automatic check_outputs();
      bit fe;
      fe = ((t % FR) == FR - 1);
      check("frame_end_a", {15'b0, fe_a}, {15'b0, fe});
      check("frame_end_b", {15'b0, fe_b}, {15'b0, fe});
      check("wr_ready_a", {15'b0, rdy_a}, {15'b0, !m_pend});
      check("wr_ready_b", {15'b0, rdy_b}, {15'b0, !m_pend});
      check("seg_a", {8'b0, seg_a}, {8'b0, m_seg_a});
      check("seg_b", {8'b0, seg_b}, {8'b0, ~m_seg_b});
      check("dig_a", {12'b0, dig_a}, {12'b0, m_dig});
      check("dig_b", {12'b0, dig_b}, {12'b0, ~m_dig});
   endtask

   // Called just after a falling edge with inputs settled for the coming rising edge.
   task automatic step();
      bit fe;
      int dg;
      check_outputs();
      @(posedge clk);
      fe = ((t % FR) == FR - 1);
      dg = (t / S) % D;
      m_dig   = disp_en ? 4'(1 << dg) : 4'h0;
      m_seg_a = disp_en ? seg_of(m_disp, m_dp, dg, 1'b0) : 8'h00;
      m_seg_b = disp_en ? seg_of(m_disp, m_dp, dg, 1'b1) : 8'h00;
      if (fe && m_pend) begin
         m_disp = m_sh; m_dp = m_shdp; m_pend = 0;
      end else if (wr_valid && !m_pend) begin
         m_sh = wr_data; m_shdp = wr_dp; m_pend = 1;
      end
      t++;
      @(negedge clk);
   endtask

   task automatic run_to(input int n);
      while (t < n) step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_ready_a", {15'b0, rdy_a}, 16'h1);
      check("rst_ready_b", {15'b0, rdy_b}, 16'h1);
      check("rst_fe_a", {15'b0, fe_a}, 16'h0);
      check("rst_seg_a", {8'b0, seg_a}, 16'h00);
      check("rst_seg_b", {8'b0, seg_b}, 16'hFF);
      check("rst_dig_a", {12'b0, dig_a}, 16'h0);
      check("rst_dig_b", {12'b0, dig_b}, 16'hF);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [15:0] mask;
      rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_dp = '0; disp_en = 1'b1;
      model_reset();
      @(negedge clk);

      // Free-running scan after reset.
      do_reset();
      run_to(40);

      // Write 1234 at cycle 3; ABCD while pending must be dropped.
      do_reset();
      run_to(3);
      wr_valid = 1'b1; wr_data = 16'h1234; wr_dp = 4'h0;
      step();
      wr_valid = 1'b0;
      step();
      wr_valid = 1'b1; wr_data = 16'hABCD;
      step();
      wr_valid = 1'b0;
      check("t2_ready_low", {15'b0, rdy_a}, 16'h0);
      run_to(16);
      check("t3_ready_back", {15'b0, rdy_a}, 16'h1);
      run_to(17); check("t2_dig0", {8'b0, seg_a}, 16'h66);
      run_to(21); check("t2_dig1", {8'b0, seg_a}, 16'hF2);
      run_to(25); check("t2_dig2", {8'b0, seg_a}, 16'hDA);
      run_to(29); check("t2_dig3", {8'b0, seg_a}, 16'h60);

      // Write on a frame_end cycle waits a full frame; exercises leading-zero blanking.
      run_to(31);
      check("t4_fe_now", {15'b0, fe_a}, 16'h1);
      wr_valid = 1'b1; wr_data = 16'h0070; wr_dp = 4'b0010;
      step();
      wr_valid = 1'b0;
      run_to(40); check("t4_still_pending", {15'b0, rdy_a}, 16'h0);
      run_to(48); check("t4_committed", {15'b0, rdy_a}, 16'h1);
      run_to(49); check("t5_b_dig0", {8'b0, seg_b}, 16'h03);
      run_to(53); check("t5_b_dig1", {8'b0, seg_b}, 16'h1E);
      run_to(57); check("t5_b_dig2", {8'b0, seg_b}, 16'hFF);
                  check("t5_a_dig2", {8'b0, seg_a}, 16'hFC);
      run_to(61); check("t5_b_dig3", {8'b0, seg_b}, 16'hFF);

      // Display disable mid-frame, then reset with a write pending.
      run_to(62);
      disp_en = 1'b0;
      step();
      check("t6_off_seg_b", {8'b0, seg_b}, 16'hFF);
      check("t6_off_dig_b", {12'b0, dig_b}, 16'hF);
      disp_en = 1'b1;
      wr_valid = 1'b1; wr_data = 16'hBEEF; wr_dp = 4'hF;
      step();
      wr_valid = 1'b0;
      step();
      check("t6_pending", {15'b0, rdy_b}, 16'h0);
      do_reset();
      run_to(20);
      check("t6_blank_after_rst", {8'b0, seg_a}, 16'hFC);

      // Randomised traffic, enables and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(3))
            0: mask = 16'hFFFF;
            1: mask = 16'h00FF;
            2: mask = 16'h000F;
            default: mask = 16'h0F0F;
         endcase
         wr_valid = ($urandom_range(7) == 0);
         wr_data  = 16'($urandom) & mask;
         wr_dp    = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
         disp_en  = ($urandom_range(7) != 0);
         if ($urandom_range(299) == 0)
            do_reset();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
